// File: rtl/conv_pkg.sv
// Shared types and constants for the 4x4 convolution feeder.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        K_FETCH = 3'd1,
        I_FETCH = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_KERNEL_SIZE = 4;
    // Cycles from conv_valid_in to the conv unit's output register latch.
    localparam int CONV_RESULT_LAT = 2;

    // Counter width helper that never returns zero.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/row_packer.sv
// Collects KERNEL_SIZE serial words into a registered row with a one-cycle valid.
// A side tag travels with the last word of each row.
module row_packer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int TAG_W       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_row [KERNEL_SIZE],
    output logic [TAG_W-1:0]      o_tag
);

    localparam int                SLOT_W    = clog2_min1(KERNEL_SIZE);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(KERNEL_SIZE - 1);

    logic [SLOT_W-1:0]     r_slot;
    logic [DATA_WIDTH-1:0] r_words [KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] r_row   [KERNEL_SIZE];
    logic                  r_valid;
    logic [TAG_W-1:0]      r_tag;
    logic                  w_last;

    assign w_last = i_valid && (r_slot == LAST_SLOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else begin
            r_valid <= w_last;
            if (i_valid) begin
                r_slot <= w_last ? '0 : r_slot + 1'b1;
            end
            if (w_last) begin
                r_tag <= i_tag;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_words[gi] <= '0;
                end else if (i_valid && (r_slot == SLOT_W'(gi))) begin
                    r_words[gi] <= i_data;
                end
            end
        end

        // The final word bypasses the slot store so the row presents one cycle after it.
        for (gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
            if (gi == KERNEL_SIZE - 1) begin : g_tail
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_row[gi] <= '0;
                    end else if (w_last) begin
                        r_row[gi] <= i_data;
                    end
                end
            end else begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_row[gi] <= '0;
                    end else if (w_last) begin
                        r_row[gi] <= r_words[gi];
                    end
                end
            end
            assign o_row[gi] = r_row[gi];
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_tag   = r_tag;

endmodule

// File: rtl/conv_4_feeder.sv
// Streams kernel rows then strip-ordered image rows into the 4x4 conv unit and
// tags each cycle where the conv output register holds a valid pixel.
module conv_4_feeder
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int ADDR_W      = $clog2(IMG_W * IMG_H),
    parameter int K_ADDR_W    = $clog2(KERNEL_SIZE * KERNEL_SIZE),
    parameter int X_W         = $clog2(IMG_W),
    parameter int Y_W         = $clog2(IMG_H)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_k_rd_en,
    output logic [K_ADDR_W-1:0]   o_k_addr,
    input  logic [DATA_WIDTH-1:0] i_k_rd_data,
    output logic                  o_img_rd_en,
    output logic [ADDR_W-1:0]     o_img_addr,
    input  logic [DATA_WIDTH-1:0] i_img_rd_data,
    output logic [DATA_WIDTH-1:0] o_row_out [KERNEL_SIZE],
    output logic                  o_kernel_load,
    output logic                  o_conv_valid_in,
    output logic                  o_conv_valid_out,
    output logic                  o_res_valid,
    output logic [X_W-1:0]        o_res_x,
    output logic [Y_W-1:0]        o_res_y
);

    localparam int                  J_W          = clog2_min1(KERNEL_SIZE);
    localparam int                  PIPE_D       = CONV_RESULT_LAT + 1;
    localparam logic [K_ADDR_W-1:0] K_LAST       = K_ADDR_W'(KERNEL_SIZE * KERNEL_SIZE - 1);
    localparam logic [J_W-1:0]      J_LAST       = J_W'(KERNEL_SIZE - 1);
    localparam logic [X_W-1:0]      X_LAST       = X_W'(IMG_W - KERNEL_SIZE);
    localparam logic [Y_W-1:0]      Y_LAST       = Y_W'(IMG_H - 1);
    localparam logic [Y_W-1:0]      Y_WIN_FIRST  = Y_W'(KERNEL_SIZE - 1);
    localparam logic [Y_W-1:0]      RES_Y_LAST   = Y_W'(IMG_H - KERNEL_SIZE);

    typedef struct packed {
        logic           is_img;
        logic           last_k;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    state_t              r_state;
    state_t              w_state_next;

    logic [K_ADDR_W-1:0] r_k_cnt;
    logic [J_W-1:0]      r_j;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [ADDR_W-1:0]   r_row_base;

    logic                r_rd_vld;
    tag_t                r_rd_tag;
    tag_t                w_issue_tag;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                w_pk_valid;
    logic [TAG_W-1:0]    w_pk_tag_bits;
    tag_t                w_pk_tag;

    logic                r_kernel_load;
    logic                r_pv [PIPE_D];
    logic [X_W-1:0]      r_px [PIPE_D];
    logic [Y_W-1:0]      r_py [PIPE_D];

    logic                w_accept;
    logic                w_k_last_issue;
    logic                w_img_last_issue;
    logic                w_final_res;
    logic                w_res_in_vld;

    assign w_accept         = (r_state == IDLE) && i_start;
    assign w_k_last_issue   = o_k_rd_en && (r_k_cnt == K_LAST);
    assign w_img_last_issue = o_img_rd_en && (r_j == J_LAST) && (r_y == Y_LAST) && (r_x == X_LAST);
    assign w_final_res      = o_res_valid && (o_res_x == X_LAST) && (o_res_y == RES_Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start)          w_state_next = K_FETCH;
            K_FETCH: if (w_k_last_issue)   w_state_next = I_FETCH;
            I_FETCH: if (w_img_last_issue) w_state_next = DRAIN;
            DRAIN:   if (w_final_res)      w_state_next = DONE;
            DONE:                          w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != IDLE);
        o_done      = (r_state == DONE);
        o_k_rd_en   = (r_state == K_FETCH);
        o_img_rd_en = (r_state == I_FETCH);
    end

    // Strip-major walk: j fastest, then y down the strip, then x to the next strip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k_cnt    <= '0;
            r_j        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
        end else if (r_state == IDLE) begin
            r_k_cnt    <= '0;
            r_j        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
        end else begin
            if (o_k_rd_en) begin
                r_k_cnt <= r_k_cnt + 1'b1;
            end
            if (o_img_rd_en) begin
                if (r_j == J_LAST) begin
                    r_j <= '0;
                    if (r_y == Y_LAST) begin
                        r_y        <= '0;
                        r_x        <= r_x + 1'b1;
                        r_row_base <= ADDR_W'(r_x) + 1'b1;
                    end else begin
                        r_y        <= r_y + 1'b1;
                        r_row_base <= r_row_base + ADDR_W'(IMG_W);
                    end
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

    assign o_k_addr   = r_k_cnt;
    assign o_img_addr = r_row_base + ADDR_W'(r_j);

    always_comb begin
        w_issue_tag.is_img = o_img_rd_en;
        w_issue_tag.last_k = w_k_last_issue;
        w_issue_tag.x      = r_x;
        w_issue_tag.y      = r_y;
    end

    // Memory data returns one cycle after issue; the tag is delayed to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= 1'b0;
            r_rd_tag <= '0;
        end else begin
            r_rd_vld <= o_k_rd_en || o_img_rd_en;
            r_rd_tag <= w_issue_tag;
        end
    end

    assign w_rd_word = r_rd_tag.is_img ? i_img_rd_data : i_k_rd_data;

    row_packer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE),
        .TAG_W       (TAG_W)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_rd_vld),
        .i_data  (w_rd_word),
        .i_tag   (r_rd_tag),
        .o_valid (w_pk_valid),
        .o_row   (o_row_out),
        .o_tag   (w_pk_tag_bits)
    );

    assign w_pk_tag        = tag_t'(w_pk_tag_bits);
    assign o_conv_valid_in = w_pk_valid;

    // Held until the final kernel row has been presented to the conv unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kernel_load <= 1'b0;
        end else if (w_accept) begin
            r_kernel_load <= 1'b1;
        end else if (w_pk_valid && w_pk_tag.last_k) begin
            r_kernel_load <= 1'b0;
        end
    end

    assign o_kernel_load = r_kernel_load;

    // The first KERNEL_SIZE-1 rows of each strip only prime the window.
    assign w_res_in_vld = w_pk_valid && w_pk_tag.is_img && (w_pk_tag.y >= Y_WIN_FIRST);

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_D; gi++) begin : g_pipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pv[gi] <= 1'b0;
                    r_px[gi] <= '0;
                    r_py[gi] <= '0;
                end else if (gi == 0) begin
                    r_pv[gi] <= w_res_in_vld;
                    r_px[gi] <= w_pk_tag.x;
                    r_py[gi] <= w_pk_tag.y - Y_WIN_FIRST;
                end else begin
                    r_pv[gi] <= r_pv[(gi == 0) ? 0 : gi - 1];
                    r_px[gi] <= r_px[(gi == 0) ? 0 : gi - 1];
                    r_py[gi] <= r_py[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign o_conv_valid_out = r_pv[CONV_RESULT_LAT-1];
    assign o_res_valid      = r_pv[CONV_RESULT_LAT];
    assign o_res_x          = r_px[CONV_RESULT_LAT];
    assign o_res_y          = r_py[CONV_RESULT_LAT];

endmodule

// File: tb/tb_conv_4_feeder.sv
// Bench for conv_4_feeder: frame-relative timing model derived from the
// stream schedule, memory models, checkpoint table and abort/restart sequence.
module tb_conv_4_feeder;

    localparam int DW      = 16;
    localparam int KS      = 4;
    localparam int W       = 28;
    localparam int H       = 28;
    localparam int AW      = 10;
    localparam int NROWS   = (W - KS + 1) * H;
    localparam int IMG_END = 17 + 4 * NROWS;
    localparam int DONE_T  = 25 + 4 * (NROWS - 1) + 1;
    localparam int FULL    = DONE_T + 4;
    localparam int NRES    = (W - KS + 1) * (H - KS + 1);

    localparam int TK_ROW   = 0;
    localparam int TK_KADDR = 1;
    localparam int TK_RES   = 2;
    localparam int TK_DONE  = 3;
    localparam int TK_KL    = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy, done;
    logic          k_rd_en;
    logic [3:0]    k_addr;
    logic [DW-1:0] k_rd_data;
    logic          img_rd_en;
    logic [AW-1:0] img_addr;
    logic [DW-1:0] img_rd_data;
    logic [DW-1:0] row_out [KS];
    logic          kernel_load, conv_valid_in, conv_valid_out, res_valid;
    logic [4:0]    res_x, res_y;

    conv_4_feeder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .o_busy           (busy),
        .o_done           (done),
        .o_k_rd_en        (k_rd_en),
        .o_k_addr         (k_addr),
        .i_k_rd_data      (k_rd_data),
        .o_img_rd_en      (img_rd_en),
        .o_img_addr       (img_addr),
        .i_img_rd_data    (img_rd_data),
        .o_row_out        (row_out),
        .o_kernel_load    (kernel_load),
        .o_conv_valid_in  (conv_valid_in),
        .o_conv_valid_out (conv_valid_out),
        .o_res_valid      (res_valid),
        .o_res_x          (res_x),
        .o_res_y          (res_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] kmem [16];
    logic [DW-1:0] imem [W*H];

    always @(posedge clk) begin
        if (k_rd_en)   k_rd_data   <= kmem[k_addr];
        if (img_rd_en) img_rd_data <= imem[img_addr];
    end

    int total = 0;
    int bad   = 0;
    int cur_t = 0;
    logic [63:0] exp_row;

    logic        tr_vin   [FULL+1];
    logic [63:0] tr_row   [FULL+1];
    logic        tr_kre   [FULL+1];
    logic [3:0]  tr_kaddr [FULL+1];
    logic        tr_kl    [FULL+1];
    logic        tr_res   [FULL+1];
    logic [9:0]  tr_rxy   [FULL+1];
    logic        tr_done  [FULL+1];

    typedef struct {
        string       name;
        int          t;
        int          kind;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, cur_t, act, exp);
        end
    endtask

    function automatic logic [63:0] row_act();
        return {row_out[0], row_out[1], row_out[2], row_out[3]};
    endfunction

    function automatic logic [31:0] ctrl_all();
        return {busy, done, k_rd_en, img_rd_en, kernel_load, conv_valid_in,
                conv_valid_out, res_valid, k_addr, img_addr, res_x, res_y};
    endfunction

    // Runs one frame starting now (called at a falling edge), checking every
    // cycle against the frame-relative schedule.
    task automatic run_frame(input bit noisy, input int len);
        int res_cnt;
        res_cnt = 0;
        start = 1'b1;
        for (int t = 1; t <= len; t++) begin
            bit   e_kre, e_ire, e_vin, e_vout, e_res, e_kl, e_busy, e_done;
            int   a_img, n, ex, ey, base;
            @(negedge clk);
            if (bad > 100) begin
                start = 1'b0;
                break;
            end
            cur_t  = t;
            e_kre  = (t >= 1 && t <= 16);
            e_ire  = (t >= 17 && t < IMG_END);
            e_kl   = (t >= 1 && t <= 18);
            e_busy = (t >= 1 && t <= DONE_T);
            e_done = (t == DONE_T);
            a_img  = 0;
            if (e_ire) begin
                n     = (t - 17) / 4;
                a_img = (n % H) * W + n / H + (t - 17) % 4;
            end
            e_vin = 1'b0;
            if (t >= 6 && t <= 18 && (t - 6) % 4 == 0) begin
                base    = 4 * ((t - 6) / 4);
                exp_row = {kmem[base], kmem[base+1], kmem[base+2], kmem[base+3]};
                e_vin   = 1'b1;
            end
            if (t >= 22 && (t - 22) % 4 == 0 && (t - 22) / 4 < NROWS) begin
                n       = (t - 22) / 4;
                base    = (n % H) * W + n / H;
                exp_row = {imem[base], imem[base+1], imem[base+2], imem[base+3]};
                e_vin   = 1'b1;
            end
            n      = (t - 24) / 4;
            e_vout = (t >= 24 && (t - 24) % 4 == 0 && n < NROWS && (n % H) >= KS - 1);
            n      = (t - 25) / 4;
            e_res  = (t >= 25 && (t - 25) % 4 == 0 && n < NROWS && (n % H) >= KS - 1);
            ex     = n / H;
            ey     = (n % H) - (KS - 1);

            check("ctrl", 80'({busy, done, k_rd_en, img_rd_en, kernel_load, conv_valid_in, conv_valid_out, res_valid}),
                  80'({e_busy, e_done, e_kre, e_ire, e_kl, e_vin, e_vout, e_res}));
            if (e_kre) check("k_addr", 80'(k_addr), 80'(t - 1));
            if (e_ire) check("img_addr", 80'(img_addr), 80'(a_img));
            check("row_out", 80'(row_act()), 80'(exp_row));
            if (e_res) check("res_xy", 80'({res_x, res_y}), 80'({5'(ex), 5'(ey)}));

            if (t <= FULL) begin
                tr_vin[t]   = conv_valid_in;
                tr_row[t]   = row_act();
                tr_kre[t]   = k_rd_en;
                tr_kaddr[t] = k_addr;
                tr_kl[t]    = kernel_load;
                tr_res[t]   = res_valid;
                tr_rxy[t]   = {res_x, res_y};
                tr_done[t]  = done;
            end
            if (res_valid) res_cnt++;

            if (noisy && t < DONE_T)       start = ($urandom_range(0, 29) == 0);
            else if (noisy && t == DONE_T) start = 1'b1;
            else                           start = 1'b0;
        end
        start = 1'b0;
        if (len == FULL) begin
            cur_t = len;
            check("res_count", 80'(res_cnt), 80'(NRES));
        end
    endtask

    initial begin
        int abort_t;
        int idle_hits;
        logic [79:0] act, exp;

        tbl[0] = '{"kaddr_first",   1,    TK_KADDR, 64'd0};
        tbl[1] = '{"krow0",         6,    TK_ROW,   {16'd1, 16'd2, 16'd3, 16'd4}};
        tbl[2] = '{"krow3",         18,   TK_ROW,   {16'd13, 16'd14, 16'd15, 16'd16}};
        tbl[3] = '{"kl_last_krow",  18,   TK_KL,    64'd1};
        tbl[4] = '{"kl_dropped",    19,   TK_KL,    64'd0};
        tbl[5] = '{"irow0",         22,   TK_ROW,   {16'd0, 16'd1, 16'd2, 16'd3}};
        tbl[6] = '{"irow28",        134,  TK_ROW,   {16'd1, 16'd2, 16'd3, 16'd4}};
        tbl[7] = '{"res_first",     37,   TK_RES,   {54'd0, 5'd0, 5'd0}};
        tbl[8] = '{"res_last",      2821, TK_RES,   {54'd0, 5'd24, 5'd24}};
        tbl[9] = '{"done_pulse",    2822, TK_DONE,  64'd0};

        rst_n   = 1'b0;
        start   = 1'b0;
        exp_row = '0;
        for (int i = 0; i < 16; i++)    kmem[i] = DW'(i + 1);
        for (int i = 0; i < W * H; i++) imem[i] = DW'(i);

        repeat (3) @(negedge clk);
        check("reset_ctrl", 80'(ctrl_all()), 80'd0);
        check("reset_row", 80'(row_act()), 80'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ctrl", 80'(ctrl_all()), 80'd0);

        // Known memory contents, quiet start line.
        run_frame(1'b0, FULL);
        for (int i = 0; i < 10; i++) begin
            int tt;
            tt    = tbl[i].t;
            cur_t = tt;
            case (tbl[i].kind)
                TK_ROW: begin
                    act = {15'd0, tr_vin[tt], tr_row[tt]};
                    exp = {15'd0, 1'b1, tbl[i].exp};
                end
                TK_KADDR: begin
                    act = {15'd0, tr_kre[tt], 60'd0, tr_kaddr[tt]};
                    exp = {15'd0, 1'b1, tbl[i].exp};
                end
                TK_RES: begin
                    act = {15'd0, tr_res[tt], 54'd0, tr_rxy[tt]};
                    exp = {15'd0, 1'b1, tbl[i].exp};
                end
                TK_DONE: begin
                    act = {15'd0, tr_done[tt], 64'd0};
                    exp = {15'd0, 1'b1, tbl[i].exp};
                end
                default: begin
                    act = 80'(tr_kl[tt]);
                    exp = 80'(tbl[i].exp);
                end
            endcase
            check(tbl[i].name, act, exp);
        end

        // Random memories, spurious starts while busy and on the done cycle.
        for (int i = 0; i < 16; i++)    kmem[i] = DW'($urandom);
        for (int i = 0; i < W * H; i++) imem[i] = DW'($urandom);
        run_frame(1'b1, FULL);

        // Abort mid-frame with an asynchronous reset, then restart cleanly.
        abort_t = $urandom_range(100, 2000);
        run_frame(1'b1, abort_t);
        #2 rst_n = 1'b0;
        #1;
        cur_t = abort_t;
        check("midrst_ctrl", 80'(ctrl_all()), 80'd0);
        check("midrst_row", 80'(row_act()), 80'd0);
        exp_row = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy || done || k_rd_en || img_rd_en) idle_hits++;
        end
        check("abort_idle", 80'(idle_hits), 80'd0);

        for (int i = 0; i < 16; i++)    kmem[i] = DW'($urandom);
        for (int i = 0; i < W * H; i++) imem[i] = DW'($urandom);
        run_frame(1'b0, FULL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
